// File: rtl/nabp_sched_pkg.sv
// Shared state encoding and default sizes for the NABP angle scheduler.
// The accumulator widths match the mapper's tMapAccuInit/tMapAccuBase types.
package nabp_sched_pkg;

   localparam int kDefAngleLength   = 8;
   localparam int kDefNoOfAngles    = 180;
   localparam int kDefShiftCount    = 256;
   localparam int kMapAccuInitWidth = 24;
   localparam int kMapAccuBaseWidth = 24;

   typedef logic [kMapAccuInitWidth-1:0] tMapAccuInit;
   typedef logic [kMapAccuBaseWidth-1:0] tMapAccuBase;

   typedef enum logic [2:0] {
      idle_s,
      setup_s,
      load_s,
      kick_s,
      shift_s
   } tSchedState;

   // The counter must be able to hold kShiftCount itself after the final shift.
   function automatic int countWidth(input int shiftCount);
      return $clog2(shiftCount + 1);
   endfunction

endpackage

// File: rtl/nabp_sched_line_counter.sv
// Per-line shift counter for the angle scheduler: clear, count enable and a
// terminal flag that is high while the next enabled shift is the last one.
module nabp_sched_line_counter #(
   parameter int kShiftCount = 256,
   parameter int kCountWidth = 9
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic last_o
);

   logic [kCountWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + kCountWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == kCountWidth'(kShiftCount - 1));

endmodule

// File: rtl/nabp_angle_scheduler.sv
// Steps the projection mapper through every angle of one back-projection pass.
// Define NABP_SCHED_STALL_EN to add the 'hold' input that stalls line shifting.
module nabp_angle_scheduler
   import nabp_sched_pkg::*;
#(
   parameter int kAngleLength   = kDefAngleLength,
   parameter int kNoOfAngles    = kDefNoOfAngles,
   parameter int kShiftCount    = kDefShiftCount,
   parameter int kAccuInitWidth = kMapAccuInitWidth,
   parameter int kAccuBaseWidth = kMapAccuBaseWidth
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
`ifdef NABP_SCHED_STALL_EN
   input  logic                      hold,
`endif
   output logic [kAngleLength-1:0]   lut_addr,
   output logic                      lut_rd,
   input  logic [kAccuInitWidth-1:0] lut_accu_init,
   input  logic [kAccuBaseWidth-1:0] lut_accu_base,
   output logic [kAccuInitWidth-1:0] mp_accu_init,
   output logic [kAccuBaseWidth-1:0] mp_accu_base,
   output logic                      sh_kick,
   output logic                      sh_shift_en,
   output logic                      sh_done,
   output logic [kAngleLength-1:0]   angle,
   output logic                      busy,
   output logic                      pass_done
);

   localparam int kCountWidth = countWidth(kShiftCount);
   localparam logic [kAngleLength-1:0] kLastAngle = kAngleLength'(kNoOfAngles - 1);

   tSchedState                state_q, state_d;
   logic [kAngleLength-1:0]   angle_q, angle_d;
   logic [kAccuInitWidth-1:0] mpAccuInit_q, mpAccuInit_d;
   logic [kAccuBaseWidth-1:0] mpAccuBase_q, mpAccuBase_d;

   logic stall;
   logic cntClear;
   logic cntLast;
   logic lutRd;
   logic shKick;
   logic shShiftEn;
   logic shDone;
   logic passDone;

`ifdef NABP_SCHED_STALL_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   nabp_sched_line_counter #(
      .kShiftCount (kShiftCount),
      .kCountWidth (kCountWidth)
   ) u_line_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (cntClear),
      .en_i    (shShiftEn),
      .last_o  (cntLast)
   );

   always_comb begin
      state_d      = state_q;
      angle_d      = angle_q;
      mpAccuInit_d = mpAccuInit_q;
      mpAccuBase_d = mpAccuBase_q;
      lutRd        = 1'b0;
      shKick       = 1'b0;
      shShiftEn    = 1'b0;
      shDone       = 1'b0;
      passDone     = 1'b0;
      cntClear     = 1'b0;

      unique case (state_q)
         idle_s: begin
            if (start) begin
               state_d = setup_s;
               angle_d = '0;
            end
         end
         setup_s: begin
            lutRd   = 1'b1;
            state_d = load_s;
         end
         load_s: begin
            mpAccuInit_d = lut_accu_init;
            mpAccuBase_d = lut_accu_base;
            state_d      = kick_s;
         end
         kick_s: begin
            shKick   = 1'b1;
            cntClear = 1'b1;
            state_d  = shift_s;
         end
         shift_s: begin
            // An aborted line still gets sh_done so the mapper drops back to ready.
            if (abort) begin
               shDone = 1'b1;
            end else begin
               shShiftEn = !stall;
               shDone    = shShiftEn && cntLast;
               if (shDone) begin
                  if (angle_q == kLastAngle) begin
                     state_d  = idle_s;
                     passDone = 1'b1;
                  end else begin
                     state_d = setup_s;
                     angle_d = angle_q + kAngleLength'(1);
                  end
               end
            end
         end
         default: state_d = idle_s;
      endcase

      if (abort) begin
         state_d = idle_s;
         angle_d = angle_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= idle_s;
         angle_q      <= '0;
         mpAccuInit_q <= '0;
         mpAccuBase_q <= '0;
      end else begin
         state_q      <= state_d;
         angle_q      <= angle_d;
         mpAccuInit_q <= mpAccuInit_d;
         mpAccuBase_q <= mpAccuBase_d;
      end
   end

   assign lut_addr     = angle_q;
   assign lut_rd       = lutRd;
   assign mp_accu_init = mpAccuInit_q;
   assign mp_accu_base = mpAccuBase_q;
   assign sh_kick      = shKick;
   assign sh_shift_en  = shShiftEn;
   assign sh_done      = shDone;
   assign angle        = angle_q;
   assign busy         = (state_q != idle_s);
   assign pass_done    = passDone;

endmodule
